// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the 1:8 channel demultiplexer.
//   WIDTH_DEF / NCH_DEF : default data width and channel count
//   canal_t             : one channel's data word at the default width
//   modo_t              : steering mode (addressed or round-robin)
package demux_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NCH_DEF   = 8;

  typedef logic [WIDTH_DEF-1:0] canal_t;

  typedef enum logic {
    ENDERECADO  = 1'b0,
    ROUND_ROBIN = 1'b1
  } modo_t;

endpackage

// File: rtl/demux_canais_canal_reg.sv
// canal_reg: one channel holding register with its full flag.
//   clk, rst  : clock, asynchronous active-high reset
//   i_wr      : load i_dado and mark the channel full
//   i_dado    : data to load
//   i_ack     : consumer strobe; empties a full channel
//   o_dado    : held data (kept after the channel is emptied)
//   o_valid   : channel full flag
//   o_err     : pulse when i_ack hits an empty channel
module canal_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_dado,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_dado,
  output logic             o_valid,
  output logic             o_err
);

  logic [WIDTH-1:0] r_dado;
  logic             r_valid;

  // A write in the same cycle as an ack wins: the channel stays full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dado  <= '0;
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_dado  <= i_dado;
      r_valid <= 1'b1;
    end else if (i_ack) begin
      r_valid <= 1'b0;
    end
  end

  assign o_dado  = r_dado;
  assign o_valid = r_valid;
  assign o_err   = i_ack & ~r_valid;

endmodule

// File: rtl/demux_canais.sv
// demux_canais: 1:NCH demultiplexer with per-channel holding registers.
//   clk, rst       : clock, asynchronous active-high reset
//   entrada        : input byte; entrada_valid / entrada_ready handshake
//   modo           : 0 = target is select, 1 = target is round-robin ptr
//   select         : addressed-mode target channel
//   saida[NCH]     : channel holding registers; saida_valid = full flags
//   saida_ack      : per-channel consume strobes
//   ptr            : round-robin pointer (advances on round-robin accepts)
//   ocupados       : number of full channels
//   erro           : sticky flag, set by an ack to an empty channel
module demux_canais
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int SEL_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] entrada,
  input  logic             entrada_valid,
  output logic             entrada_ready,
  input  logic             modo,
  input  logic [SEL_W-1:0] select,
  output logic [WIDTH-1:0] saida [NCH],
  output logic [NCH-1:0]   saida_valid,
  input  logic [NCH-1:0]   saida_ack,
  output logic [SEL_W-1:0] ptr,
  output logic [SEL_W:0]   ocupados,
  output logic             erro
);

  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W:0]   r_ocupados;
  logic             r_erro;

  logic [SEL_W-1:0] w_alvo;
  logic             w_ready;
  logic             w_aceita;
  logic [NCH-1:0]   w_wr;
  logic [NCH-1:0]   w_err;
  logic             w_inc;
  logic [SEL_W:0]   w_dec;

  assign w_alvo   = (modo_t'(modo) == ROUND_ROBIN) ? r_ptr : select;
  // A full channel being acked this cycle can be refilled in the same cycle.
  assign w_ready  = !saida_valid[w_alvo] || saida_ack[w_alvo];
  assign w_aceita = entrada_valid && w_ready;

  always_comb begin
    w_wr = '0;
    if (w_aceita) w_wr[w_alvo] = 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_canal
      canal_reg #(.WIDTH(WIDTH)) u_canal (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr[gi]),
        .i_dado  (entrada),
        .i_ack   (saida_ack[gi]),
        .o_dado  (saida[gi]),
        .o_valid (saida_valid[gi]),
        .o_err   (w_err[gi])
      );
    end
  endgenerate

  // Only fills of empty channels add, and only acks that are not overridden
  // by a same-cycle write subtract, so the count tracks popcount(saida_valid).
  always_comb begin
    w_inc = w_aceita && !saida_valid[w_alvo];
    w_dec = '0;
    for (int i = 0; i < NCH; i++) begin
      if (saida_ack[i] && saida_valid[i] && !w_wr[i]) w_dec = w_dec + (SEL_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_ocupados <= '0;
      r_erro     <= 1'b0;
    end else begin
      // NCH is a power of two, so the pointer wraps by overflow.
      if (w_aceita && (modo_t'(modo) == ROUND_ROBIN)) r_ptr <= r_ptr + SEL_W'(1);
      r_ocupados <= r_ocupados + {{SEL_W{1'b0}}, w_inc} - w_dec;
      r_erro     <= r_erro | (|w_err);
    end
  end

  assign entrada_ready = w_ready;
  assign ptr           = r_ptr;
  assign ocupados      = r_ocupados;
  assign erro          = r_erro;

endmodule

// File: doc/demux_canais.md
# demux_canais

One-to-eight demultiplexer with per-channel holding registers, the distributing counterpart of the team's 8:1 channel mux. It takes a single 8-bit input stream with a valid/ready handshake and steers each byte into one of eight channel registers. A byte is steered either by an explicit `select` or by an internal round-robin pointer. Each channel holds its byte until the consumer acknowledges it, so the block sits between a shared producer bus and eight independent consumers.

## Interface
Parameters:
- `WIDTH`, 8: channel data width.
- `NCH`, 8: number of channels. Must be a power of two.
- `SEL_W`, `$clog2(NCH)`: select and pointer width. Derived; do not override.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous reset, active-high.
- `entrada`, in, WIDTH: input data byte.
- `entrada_valid`, in, 1: `entrada` holds a byte to deliver.
- `entrada_ready`, out, 1: the target channel can accept this cycle.
- `modo`, in, 1: 0 = addressed mode (target = `select`); 1 = round-robin mode (target = `ptr`).
- `select`, in, SEL_W: target channel in addressed mode.
- `saida[NCH]`, out, WIDTH each: channel holding registers.
- `saida_valid`, out, NCH: per-channel full flag.
- `saida_ack`, in, NCH: per-channel consume strobe.
- `ptr`, out, SEL_W: round-robin pointer.
- `ocupados`, out, SEL_W+1: count of full channels, 0..NCH.
- `erro`, out, 1: sticky; set by an ack to an empty channel.

## Operation
- Target `t` = `modo ? ptr : select`.
- `entrada_ready` = `!saida_valid[t] || saida_ack[t]`. This is combinational, so a full channel being acked in the same cycle can be refilled.
- Accept = `entrada_valid && entrada_ready`. On accept: `saida[t]` ← `entrada`, `saida_valid[t]` ← 1.
- Ack: `saida_ack[i] && saida_valid[i]` without a write to channel i → `saida_valid[i]` ← 0. `saida[i]` keeps its old value.
- Ack and write to the same channel in the same cycle: the write wins. Valid stays 1 and the data is replaced.
- Ack to an empty channel: no data or valid change; `erro` ← 1. `erro` stays set until `rst`.
- Multiple acks in one cycle are legal. Each channel is handled independently.
- `ptr`: increments only on an accept while `modo`=1, and wraps from NCH-1 to 0. It holds when `modo`=0. Changing `modo` does not reset `ptr`.
- `ocupados` is updated every cycle by +(accepts into empty channels) − (acks of full channels not rewritten).
  - Net change is in {-NCH..+1}.
  - It always equals the popcount of `saida_valid`.
  - It never exceeds NCH and never underflows.
- No accept occurs without `entrada_valid`. `entrada`, `select` and `modo` are ignored when `entrada_valid`=0.

## Timing
- Reset values: all `saida` = 0, `saida_valid` = 0, `ptr` = 0, `ocupados` = 0, `erro` = 0. Consequently `entrada_ready` = 1 out of reset.
- Reset mid-operation clears all state immediately (asynchronous). In-flight bytes are lost and no ack is required.
- Latency: a byte accepted at edge N appears on `saida[t]` with `saida_valid[t]`=1 after edge N. `ptr` and `ocupados` also update at edge N.
- Ack takes effect at the same edge. The consumer may hold ack for one cycle only; a held ack on a now-empty channel sets `erro`.
- Back-to-back accepts at full rate are possible in round-robin mode while the targeted channels are empty.
- The producer must hold `entrada` and `entrada_valid` stable while ready=0. The bench checks this.

## Structure
- Shared package `demux_pkg`:
  - `WIDTH` and `NCH` defaults.
  - `typedef logic [WIDTH-1:0] canal_t`.
  - `typedef enum logic {ENDERECADO, ROUND_ROBIN} modo_t`.
- Sub-module `canal_reg`: one channel's data register, valid flag and per-channel error pulse (inputs: write, data, ack). It is instantiated NCH times in a generate loop.
- The top level holds:
  - target/ready muxing;
  - the `ptr` counter;
  - the `ocupados` counter;
  - the `erro` OR-reduction.

## Test plan
- Reset, then `modo`=0, `select`=3, `entrada`=8'hA5, valid for 1 cycle → next cycle `saida[3]`=A5, `saida_valid`=8'b0000_1000, `ocupados`=1, `ptr`=0.
- `modo`=1, 9 consecutive valid bytes 01..09 with no acks → bytes 01..08 land in channels 0..7. `ptr` wraps to 0 and `ocupados`=8. The 9th byte stalls with ready=0 until `saida_ack[0]`.
- Channel 2 full (8'h11); same cycle `saida_ack[2]`=1, `select`=2, `entrada`=8'h22 → `saida[2]`=22, valid stays 1, `ocupados` unchanged.
- `saida_ack`=8'hFF with only channels 0 and 5 full → both cleared, `ocupados` drops by 2, `erro`=1 and it stays 1.
- Assert `rst` mid-stream with 4 channels full and `ptr`=4 → all outputs 0 asynchronously, before the next clock edge; `entrada_ready`=1 after release.
- Random mix of modes, selects and acks (≥10k cycles) against a scoreboard → `ocupados` always equals popcount(`saida_valid`), no byte lost or duplicated.
